periph_responder: RTL
=====================

PERIPH_RESPONDER -- requirements
Module: periph_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h40000000: base byte address of the peripheral window.
REQ-002 SHALL have parameter TICK_DIV, default 1: clock cycles per timer increment, range 1..65535.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: reset is asynchronous and active-low.
REQ-005 SHALL have port Address  input  32: byte address from the pipeline MEM stage.
REQ-006 SHALL have port WriteData  input  32: store data.
REQ-007 SHALL have port MemRead  input  1: load request, this cycle.
REQ-008 SHALL have port MemWrite  input  1: store request, this cycle.
REQ-009 SHALL have port ReadData  output  32: load response.
REQ-010 SHALL have port irq  output  1: timer interrupt request, level.
REQ-011 SHALL have port led  output  16: LED register contents.
REQ-012 SHALL have port digit  output  16: display value register contents, fed to the 7-segment driver.

Function
REQ-013 SHALL decode a hit when Address[31:5] == BASE_ADDR[31:5]; offset = Address[4:2]; Address[1:0] ignored.
REQ-014 SHALL implement registers: offset 0 TH (RW, 32), 1 TL (RW, 32), 2 TCON (RW, 3), 3 LED (RW, 16), 4 DIGIT (RW, 16), 5 SYSTICK (RO, 32); offsets 6-7 unmapped.
REQ-015 SHALL drive ReadData combinationally (zero-cycle latency) with the addressed register, zero-extended, when MemRead=1 and hit; otherwise 32'h0.
REQ-016 SHALL perform a store at the rising edge when MemWrite=1 and hit; LED/DIGIT take WriteData[15:0].
REQ-017 SHALL ignore stores to SYSTICK and unmapped offsets; loads from unmapped offsets return 0.
REQ-018 SHALL, with MemRead and MemWrite both 1, return the pre-store register value on ReadData and apply the store at the edge.
REQ-019 SHALL define TCON bit0 = timer enable, bit1 = interrupt enable, bit2 = overflow status.
REQ-020 SHALL on TCON store load bits[1:0] from WriteData[1:0] and clear bit2 only when WriteData[2]=1 (write-one-to-clear).
REQ-021 SHALL run a prescaler counting 0..TICK_DIV-1 while enable=1, holding its value while enable=0; a tick occurs when it wraps to 0.
REQ-022 SHALL on each tick increment TL by 1, except when TL == 32'hFFFFFFFF, where TL loads TH and bit2 sets.
REQ-023 SHALL drive irq = TCON[2] & TCON[1], registered-state only (no combinational path from bus inputs).
REQ-024 SHALL give a CPU store to TL priority over a same-cycle tick (stored value lands; no increment that cycle).
REQ-025 SHALL give overflow-set priority over a same-cycle W1C clear of bit2 (status remains 1).
REQ-026 SHALL let a TH store coincident with overflow reload TL with the old TH value.
REQ-027 SHALL increment SYSTICK every cycle out of reset, wrapping 32'hFFFFFFFF -> 0, independent of TCON.
REQ-028 SHALL not stall or back-pressure the pipeline; every access completes in the request cycle.

Reset
REQ-029 SHALL, while reset=0, asynchronously force TH, TL, TCON, LED, DIGIT, SYSTICK and prescaler to 0, hence led=0, digit=0, irq=0.
REQ-030 SHALL keep ReadData combinational during reset (reads return the reset value 0).
REQ-031 SHALL, on reset assertion mid-count, abandon pending ticks; counting resumes only after a new TCON enable store.

Verification
REQ-032 Bench SHALL check: store 32'hFFFFFFFD to TH and TL, TCON=3 (TICK_DIV=1) -> TL reads FFFFFFFE, FFFFFFFF, then FFFFFFFD with TCON=7 and irq=1 on 3rd cycle after enable.
REQ-033 Bench SHALL check: with irq=1, store TCON=4'b0111 -> bit2 clears, irq=0 next cycle; repeat with the store on an overflow cycle -> irq stays 1.
REQ-034 Bench SHALL check: store 16'hA5A5 to LED, 16'h1234 to DIGIT -> led=A5A5, digit=1234 after edge; load offsets 3/4 returns 0000A5A5/00001234.
REQ-035 Bench SHALL check: load Address 32'h40000018, 32'h3FFFFFFC, and SYSTICK store of 32'hDEAD -> ReadData 0, 0, SYSTICK unaffected and still incrementing.
REQ-036 Bench SHALL check: TICK_DIV=4, TL=0, enable -> TL=1 after 4 cycles, 2 after 8; store TL=100 on a tick cycle -> TL reads 100.
REQ-037 Bench SHALL check: reset=0 pulse mid-count (no clock edge) -> all registers, led, digit, irq 0 immediately; TL frozen after release until TCON enabled.

Source files
------------

// File: rtl/periph_responder.sv
// periph_responder -- memory-mapped timer / LED / display peripheral for the
// pipeline MEM stage. Every access completes in the request cycle.
//
// Register map (word offset = Address[4:2], hit when Address[31:5] matches
// BASE_ADDR[31:5]):
//   0 TH      RW 32  timer reload value
//   1 TL      RW 32  timer count
//   2 TCON    RW  3  bit0 enable, bit1 irq enable, bit2 overflow (W1C)
//   3 LED     RW 16
//   4 DIGIT   RW 16
//   5 SYSTICK RO 32  free-running cycle counter
//   6,7       unmapped (reads 0, stores ignored)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low
//   Address    byte address
//   WriteData  store data
//   MemRead    load request
//   MemWrite   store request
//   ReadData   combinational load response (0 when not a read hit)
//   irq        TCON[2] & TCON[1]
//   led        LED register
//   digit      DIGIT register
module periph_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        irq,
  output logic [15:0] led,
  output logic [15:0] digit
);

  localparam logic [2:0]  OFF_TH      = 3'd0;
  localparam logic [2:0]  OFF_TL      = 3'd1;
  localparam logic [2:0]  OFF_TCON    = 3'd2;
  localparam logic [2:0]  OFF_LED     = 3'd3;
  localparam logic [2:0]  OFF_DIGIT   = 3'd4;
  localparam logic [2:0]  OFF_SYSTICK = 3'd5;
  localparam logic [31:0] ALL_ONES    = 32'hFFFF_FFFF;
  localparam logic [15:0] DIV_LAST    = 16'(TICK_DIV - 1);

  logic [31:0] th_r;
  logic [31:0] tl_r;
  logic [2:0]  tcon_r;
  logic [15:0] led_r;
  logic [15:0] digit_r;
  logic [31:0] systick_r;
  logic [15:0] presc_r;

  logic        hit_s;
  logic [2:0]  off_s;
  logic        wr_s;
  logic        tl_wr_s;
  logic        tick_s;
  logic        ovf_s;
  logic [31:0] th_nxt_s;
  logic [31:0] tl_nxt_s;
  logic [2:0]  tcon_nxt_s;
  logic [15:0] led_nxt_s;
  logic [15:0] digit_nxt_s;
  logic [15:0] presc_nxt_s;

  assign hit_s   = (Address[31:5] == BASE_ADDR[31:5]);
  assign off_s   = Address[4:2];
  assign wr_s    = MemWrite & hit_s;
  assign tl_wr_s = wr_s & (off_s == OFF_TL);

  // A tick is the prescaler wrapping back to zero while enabled.
  assign tick_s = tcon_r[0] & (presc_r == DIV_LAST);
  // A CPU store to TL swallows the tick entirely, so it cannot overflow either.
  assign ovf_s  = tick_s & ~tl_wr_s & (tl_r == ALL_ONES);

  assign irq   = tcon_r[2] & tcon_r[1];
  assign led   = led_r;
  assign digit = digit_r;

  // Load mux: zero-latency, returns the pre-store value on a read+write cycle.
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && hit_s) begin
      case (off_s)
        OFF_TH:      ReadData = th_r;
        OFF_TL:      ReadData = tl_r;
        OFF_TCON:    ReadData = {29'h0, tcon_r};
        OFF_LED:     ReadData = {16'h0, led_r};
        OFF_DIGIT:   ReadData = {16'h0, digit_r};
        OFF_SYSTICK: ReadData = systick_r;
        default:     ReadData = 32'h0;
      endcase
    end else begin
      ReadData = 32'h0;
    end
  end

  // Prescaler next value: counts only while enabled, holds otherwise.
  always_comb begin
    presc_nxt_s = presc_r;
    if (tcon_r[0]) begin
      if (tick_s) begin
        presc_nxt_s = 16'h0;
      end else begin
        presc_nxt_s = presc_r + 16'h1;
      end
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Register next values: timer update first, CPU stores override it.
  always_comb begin
    th_nxt_s    = th_r;
    tl_nxt_s    = tl_r;
    tcon_nxt_s  = tcon_r;
    led_nxt_s   = led_r;
    digit_nxt_s = digit_r;

    if (tick_s) begin
      if (tl_r == ALL_ONES) begin
        // Reload uses the current TH, so a same-cycle TH store is not seen yet.
        tl_nxt_s = th_r;
      end else begin
        tl_nxt_s = tl_r + 32'h1;
      end
    end else begin
      tl_nxt_s = tl_r;
    end

    if (ovf_s) begin
      tcon_nxt_s[2] = 1'b1;
    end else begin
      tcon_nxt_s[2] = tcon_r[2];
    end

    if (wr_s) begin
      case (off_s)
        OFF_TH:    th_nxt_s = WriteData;
        OFF_TL:    tl_nxt_s = WriteData;
        OFF_TCON: begin
          tcon_nxt_s[1:0] = WriteData[1:0];
          // Overflow set wins over a coincident write-one-to-clear.
          if (WriteData[2] && !ovf_s) begin
            tcon_nxt_s[2] = 1'b0;
          end else begin
            tcon_nxt_s[2] = tcon_r[2] | ovf_s;
          end
        end
        OFF_LED:   led_nxt_s   = WriteData[15:0];
        OFF_DIGIT: digit_nxt_s = WriteData[15:0];
        default: begin
          th_nxt_s = th_nxt_s;
        end
      endcase
    end else begin
      th_nxt_s = th_nxt_s;
    end
  end

  // State registers; reset clears everything, including any pending prescale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_r      <= 32'h0;
      tl_r      <= 32'h0;
      tcon_r    <= 3'h0;
      led_r     <= 16'h0;
      digit_r   <= 16'h0;
      systick_r <= 32'h0;
      presc_r   <= 16'h0;
    end else begin
      th_r      <= th_nxt_s;
      tl_r      <= tl_nxt_s;
      tcon_r    <= tcon_nxt_s;
      led_r     <= led_nxt_s;
      digit_r   <= digit_nxt_s;
      systick_r <= systick_r + 32'h1;
      presc_r   <= presc_nxt_s;
    end
  end

endmodule
